// File: rtl/fbwriter3_if.sv
// PLB master IPIF signal bundle between fbwriter3 (master) and the bus
// attachment (slave). Bit 0 is the MSB on every vector, as on the PLB.
interface fbwriter3_if;
    logic        IP2Bus_MstRd_Req;
    logic        IP2Bus_MstWr_Req;
    logic [0:31] IP2Bus_Mst_Addr;
    logic [0:3]  IP2Bus_Mst_BE;
    logic        IP2Bus_Mst_Lock;
    logic        IP2Bus_Mst_Reset;
    logic [0:31] IP2Bus_MstWr_d;
    logic [0:31] Bus2IP_MstRd_d;
    logic        Bus2IP_Mst_CmdAck;
    logic        Bus2IP_Mst_Cmplt;
    logic        Bus2IP_Mst_Error;

    modport master (
        output IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
               IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
        input  Bus2IP_MstRd_d, Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error
    );

    modport slave (
        input  IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
               IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
        output Bus2IP_MstRd_d, Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error
    );
endinterface

// File: rtl/fbwriter3.sv
// Rasteriser-side framebuffer writer: depth-tested pixel writes over PLB IPIF,
// double-buffer swap and DMA clear on flush. Optional scissor: FBW_SCISSOR_EN.
module fbwriter3 #(
    parameter int              LINE_W        = 9,
    parameter int              COL_W         = 10,
    parameter int              BASE_W        = 28 - LINE_W - COL_W,
    parameter logic [BASE_W-1:0] FB_BASE     = 9'b1001_0000_0,
    parameter logic [31:0]     FB_CNTL_ADDR  = 32'h40A0_8000,
    parameter logic [31:0]     DMA_CNTL_ADDR = 32'hC000_0000,
    parameter logic [31:0]     FB_BYTES      = 32'h0040_0000,
    parameter int              MAX_RETRY     = 3
`ifdef FBW_SCISSOR_EN
    ,
    parameter int              MAX_COL       = 639,
    parameter int              MAX_LINE      = 479
`endif
) (
    input  logic        PLB_clk,
    input  logic        reset,
    input  logic        Bus2IP_Reset,
    input  logic [0:95] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [2:0]  depth_func,
    input  logic        depth_wr_en,
    fbwriter3_if.master bus,
    output logic        busy,
    output logic        buffer,
    output logic [15:0] frag_cnt,
    output logic [7:0]  err_cnt,
    output logic [3:0]  dbg_state
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    if (BASE_W + LINE_W + COL_W + 4 != 32) begin : g_width_check
        $error("fbwriter3: address fields must total 32 bits");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_LATCH, S_READ_Z, S_WRITE_C, S_WRITE_Z,
        S_DVI_REG, S_DMA_SA, S_DMA_DA, S_DMA_LEN
    } state_t;

    state_t            state, next_state;
    logic              rst;
    logic              req_active;
    logic [RW-1:0]     retry_cnt;
    logic [LINE_W-1:0] f_line;
    logic [COL_W-1:0]  f_col;
    logic [31:0]       f_colour, f_z;
    logic [2:0]        f_func;
    logic              f_wr_en;

    logic              rd_pulse, do_latch, start_req, retry;
    logic              frag_inc, err_inc, buf_toggle;
    logic              in_bus, bus_rd;
    logic [31:0]       bus_addr, bus_wdata, rd_z;
    logic              flush_tok, out_of_range;
    logic [31:0]       pix_c, pix_z;

    assign rst       = reset | Bus2IP_Reset;
    assign flush_tok = &fifo_data;
    assign rd_z      = bus.Bus2IP_MstRd_d;
    assign pix_c     = {FB_BASE, buffer, 1'b0, f_line, f_col, 2'b00};
    assign pix_z     = {FB_BASE, buffer, 1'b1, f_line, f_col, 2'b00};

`ifdef FBW_SCISSOR_EN
    assign out_of_range = (32'(fifo_data[32-COL_W:31]) > MAX_COL) ||
                          (32'(fifo_data[16-LINE_W:15]) > MAX_LINE);
`else
    assign out_of_range = 1'b0;
`endif

    function automatic logic depth_pass(input logic [2:0] f,
                                        input logic [31:0] zn, input logic [31:0] zo);
        case (f)
            3'd0:    return 1'b0;
            3'd1:    return zn <  zo;
            3'd2:    return zn == zo;
            3'd3:    return zn <= zo;
            3'd4:    return zn >  zo;
            3'd5:    return zn != zo;
            3'd6:    return zn >= zo;
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        next_state = state;
        rd_pulse   = 1'b0;
        do_latch   = 1'b0;
        start_req  = 1'b0;
        retry      = 1'b0;
        frag_inc   = 1'b0;
        err_inc    = 1'b0;
        buf_toggle = 1'b0;
        in_bus     = 1'b0;
        bus_rd     = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    rd_pulse   = 1'b1;
                    next_state = S_LATCH;
                end
            end
            S_LATCH: begin
                do_latch = 1'b1;
                if (flush_tok) begin
                    next_state = S_DVI_REG;
                    start_req  = 1'b1;
                end else if (out_of_range) begin
                    next_state = S_IDLE;
                end else if (depth_func == 3'd7) begin
                    next_state = S_WRITE_C;
                    start_req  = 1'b1;
                end else if (depth_func == 3'd0) begin
                    next_state = S_IDLE;
                end else begin
                    next_state = S_READ_Z;
                    start_req  = 1'b1;
                end
            end
            default: begin
                in_bus = 1'b1;
                case (state)
                    S_READ_Z:  begin bus_addr = pix_z; bus_rd = 1'b1; end
                    S_WRITE_C: begin bus_addr = pix_c; bus_wdata = f_colour; end
                    S_WRITE_Z: begin bus_addr = pix_z; bus_wdata = f_z; end
                    S_DVI_REG: begin
                        bus_addr  = FB_CNTL_ADDR;
                        bus_wdata = {FB_BASE, buffer, {(31-BASE_W){1'b0}}};
                    end
                    S_DMA_SA: begin
                        bus_addr  = DMA_CNTL_ADDR + 32'd8;
                        bus_wdata = {FB_BASE + BASE_W'(1), 1'b1, {(31-BASE_W){1'b0}}};
                    end
                    S_DMA_DA: begin
                        bus_addr  = DMA_CNTL_ADDR + 32'd12;
                        bus_wdata = {FB_BASE, ~buffer, {(31-BASE_W){1'b0}}};
                    end
                    default: begin
                        bus_addr  = DMA_CNTL_ADDR + 32'd16;
                        bus_wdata = FB_BYTES;
                    end
                endcase
                if (bus.Bus2IP_Mst_Cmplt) begin
                    if (bus.Bus2IP_Mst_Error) begin
                        if (retry_cnt < RW'(MAX_RETRY)) begin
                            retry = 1'b1;
                        end else begin
                            err_inc    = 1'b1;
                            next_state = S_IDLE;
                        end
                    end else begin
                        case (state)
                            S_READ_Z: begin
                                if (depth_pass(f_func, f_z, rd_z)) begin
                                    next_state = S_WRITE_C;
                                    start_req  = 1'b1;
                                end else begin
                                    next_state = S_IDLE;
                                end
                            end
                            S_WRITE_C: begin
                                if (f_wr_en) begin
                                    next_state = S_WRITE_Z;
                                    start_req  = 1'b1;
                                end else begin
                                    next_state = S_IDLE;
                                    frag_inc   = 1'b1;
                                end
                            end
                            S_WRITE_Z: begin
                                next_state = S_IDLE;
                                frag_inc   = 1'b1;
                            end
                            S_DVI_REG: begin next_state = S_DMA_SA;  start_req = 1'b1; end
                            S_DMA_SA:  begin next_state = S_DMA_DA;  start_req = 1'b1; end
                            S_DMA_DA:  begin next_state = S_DMA_LEN; start_req = 1'b1; end
                            default: begin
                                next_state = S_IDLE;
                                buf_toggle = 1'b1;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge PLB_clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_active <= 1'b0;
            retry_cnt  <= '0;
            f_line     <= '0;
            f_col      <= '0;
            f_colour   <= '0;
            f_z        <= '0;
            f_func     <= '0;
            f_wr_en    <= 1'b0;
            buffer     <= 1'b0;
            frag_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            state <= next_state;
            // A new or reissued request wins over the CmdAck of the one just finished.
            if (start_req || retry)
                req_active <= 1'b1;
            else if (bus.Bus2IP_Mst_CmdAck)
                req_active <= 1'b0;
            if (start_req)
                retry_cnt <= '0;
            else if (retry)
                retry_cnt <= retry_cnt + RW'(1);
            if (do_latch) begin
                f_line   <= fifo_data[16-LINE_W:15];
                f_col    <= fifo_data[32-COL_W:31];
                f_colour <= fifo_data[32:63];
                f_z      <= fifo_data[64:95];
                f_func   <= depth_func;
                f_wr_en  <= depth_wr_en;
            end
            if (frag_inc)
                frag_cnt <= frag_cnt + 16'd1;
            if (err_inc && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
            if (buf_toggle)
                buffer <= ~buffer;
        end
    end

    // Requests are gated by reset so an in-flight command drops in the same cycle.
    assign fifo_rd_en           = rd_pulse & ~rst;
    assign bus.IP2Bus_MstRd_Req = req_active & in_bus &  bus_rd & ~rst;
    assign bus.IP2Bus_MstWr_Req = req_active & in_bus & ~bus_rd & ~rst;
    assign bus.IP2Bus_Mst_Addr  = bus_addr;
    assign bus.IP2Bus_MstWr_d   = bus_wdata;
    assign bus.IP2Bus_Mst_BE    = 4'b1111;
    assign bus.IP2Bus_Mst_Lock  = 1'b0;
    assign bus.IP2Bus_Mst_Reset = 1'b0;
    assign busy                 = (state != S_IDLE);
    assign dbg_state            = state;

endmodule
